trap_ctrl: RTL
==============

// Module: trap_ctrl
// PURPOSE
// - Trap sequencer directly upstream of the machine CSR file.
// - Arbitrates synchronous exceptions, mret and machine interrupts (SW/timer/ext), drains the pipeline, then
//   issues the one-cycle trap/mret commit strobe (ctrl_trap, ctrl_mret, trap_pc, trap_info) to the CSR file.
// - Then issues the fetch redirect (mtvec or mepc).
// PARAMETERS
// - DRAIN_TIMEOUT  16  max cycles spent in DRAIN waiting for pipe_idle; 0 = wait forever
// PORTS
// - ctrl_clk         in   1   clock
// - ctrl_reset_n     in   1   reset, asynchronous, active-low
// - exc_valid        in   1   synchronous exception from execute stage
// - exc_cause        in   4   exception code (0..15)
// - exc_pc           in   32  pc of faulting instruction
// - mret_req         in   1   mret retiring
// - irq_sw/irq_timer/irq_ext in 1 each: raw level interrupt lines
// - irq_en           in   3   {MEIE,MTIE,MSIE} = CSR mie[11],mie[7],mie[3]
// - ctrl_mie         in   1   mstatus.MIE from CSR file
// - next_pc          in   32  pc of next unexecuted instruction (mepc for interrupts)
// - mtvec            in   32  CSR mtvec value
// - mepc             in   32  CSR mepc value
// - pipe_drain_req   out  1   request pipeline stop/flush
// - pipe_idle        in   1   no in-flight CSR write or memory op
// - ctrl_trap        out  1   commit strobe to CSR file
// - ctrl_mret        out  1   qualifies ctrl_trap as mret
// - trap_pc          out  32  mepc value to write
// - trap_info        out  5   {is_interrupt, cause[3:0]}
// - redirect_valid   out  1   fetch redirect request
// - redirect_pc      out  32  redirect target
// - redirect_ready   in   1   fetch accepts redirect
// - drain_timeout    out  1   sticky: a DRAIN ended by timeout; cleared only by reset
// BEHAVIOUR
// - Reset (ctrl_reset_n=0, async, any state): state=IDLE; every output and latched field 0.
// - FSM IDLE -> DRAIN -> COMMIT -> REDIRECT -> IDLE.
// - IDLE: priority exc_valid > mret_req > interrupt.
//   - Exception latches {0,exc_cause} and exc_pc.
//   - mret latches kind=MRET.
//   - Interrupt taken only if ctrl_mie=1 and (irq & irq_en)!=0; priority ext(11) > sw(3) > timer(7);
//     latches {1,code} and next_pc.
//   - On any take: next state DRAIN; pipe_drain_req=1 registered from the following cycle.
// - DRAIN: pipe_drain_req=1.
//   - pipe_idle=1 -> COMMIT.
//   - DRAIN_TIMEOUT!=0 and DRAIN_TIMEOUT cycles elapsed without pipe_idle -> COMMIT and set drain_timeout.
//   - Counter clears on DRAIN entry.
// - COMMIT: exactly one cycle.
//   - ctrl_trap=1; ctrl_mret=1 for MRET, else 0; trap_pc/trap_info = latched values (0 for MRET).
//   - pipe_drain_req stays 1.
// - REDIRECT: redirect_valid=1, pipe_drain_req=1; target computed from mtvec/mepc sampled in this state
//   (post-commit values).
//   - MRET: {mepc[31:2],2'b00}.
//   - Otherwise: {mtvec[31:2],2'b00} (direct).
//   - Hold valid and target stable until redirect_ready=1; that cycle -> IDLE, valid and drain drop next cycle.
// - Addition is 32-bit modulo 2^32 (wrap, no error).
// - Events while not IDLE are ignored and not queued. Upstream flushes; a level irq re-arbitrates in IDLE.
// - irq deasserting or ctrl_mie clearing after IDLE take: trap still completes with the latched cause.
// - Simultaneous exc_valid+mret_req+irq in IDLE: exception only.
// - Latency, exception with pipe_idle already 1: ctrl_trap 2 cycles after exc_valid; redirect_valid 3 cycles after.
// CONFIGURATION
// - TRAP_VECTORED_EN defined: if mtvec[1:0]==1 and the trap is an interrupt,
//   redirect_pc = {mtvec[31:2],2'b00} + (cause<<2). Exceptions and MRET unchanged.
// - TRAP_VECTORED_EN undefined: mtvec[1:0] ignored, always direct mode.
// TESTING
// - Exception: exc_valid=1, cause=2, exc_pc=0x100, pipe_idle=1, mtvec=0x200
//   -> ctrl_trap pulse, trap_info=5'h02, trap_pc=0x100; redirect_pc=0x200 held until redirect_ready.
// - Priority: irq_ext=irq_timer=irq_sw=1, irq_en=3'b111, ctrl_mie=1, next_pc=0x40 -> trap_info=5'h1B, trap_pc=0x40.
//   - Same with ctrl_mie=0 -> no drain, FSM stays IDLE.
// - mret: mret_req=1, mepc=0x87 -> ctrl_trap=ctrl_mret=1 one cycle, redirect_pc=0x84.
// - Timeout: DRAIN_TIMEOUT=4, pipe_idle=0 forever -> ctrl_trap 4 cycles into DRAIN, drain_timeout=1 sticky.
// - Vectored (TRAP_VECTORED_EN): mtvec=0x301, irq_timer -> redirect_pc=0x31C.
//   - Exception cause 3 with same mtvec -> redirect_pc=0x300.
// - Reset mid-REDIRECT with redirect_ready=0 -> outputs 0 immediately; no further ctrl_trap after release.

Source files
------------

// File: rtl/trap_ctrl.sv
// Trap sequencer between the pipeline and the machine CSR file: arbitrates exceptions, mret and interrupts,
// drains the pipe, strobes the commit, then redirects fetch. Define TRAP_VECTORED_EN for vectored interrupt entry.
module trap_ctrl #(
  parameter int unsigned DRAIN_TIMEOUT = 16
) (
  input  logic        ctrl_clk,
  input  logic        ctrl_reset_n,
  input  logic        exc_valid,
  input  logic [3:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic        mret_req,
  input  logic        irq_sw,
  input  logic        irq_timer,
  input  logic        irq_ext,
  input  logic [2:0]  irq_en,
  input  logic        ctrl_mie,
  input  logic [31:0] next_pc,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        pipe_drain_req,
  input  logic        pipe_idle,
  output logic        ctrl_trap,
  output logic        ctrl_mret,
  output logic [31:0] trap_pc,
  output logic [4:0]  trap_info,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        drain_timeout
);

  localparam int unsigned CNT_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DRAIN    = 2'd1,
    S_COMMIT   = 2'd2,
    S_REDIRECT = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_mret_q, is_mret_d;
  logic [4:0]        info_q, info_d;
  logic [31:0]       pc_q, pc_d;
  logic              timeout_q, timeout_d;
  logic              drain_req_q, drain_req_d;
  logic              trap_q, trap_d;
  logic              mret_q, mret_d;
  logic [31:0]       trap_pc_q, trap_pc_d;
  logic [4:0]        trap_info_q, trap_info_d;

  logic [2:0]        pend_s;
  logic [3:0]        irq_code_s;
  logic [31:0]       target_s;

  // Pending enabled interrupts and their fixed-priority code (ext > sw > timer)
  always_comb begin
    pend_s = {irq_ext, irq_timer, irq_sw} & irq_en;
    if (pend_s[2]) begin
      irq_code_s = 4'd11;
    end else if (pend_s[0]) begin
      irq_code_s = 4'd3;
    end else begin
      irq_code_s = 4'd7;
    end
  end

  // Next-state logic, latched trap fields and the registered output values
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_mret_d = is_mret_q;
    info_d    = info_q;
    pc_d      = pc_q;
    timeout_d = timeout_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (exc_valid) begin
          is_mret_d = 1'b0;
          info_d    = {1'b0, exc_cause};
          pc_d      = exc_pc;
          state_d   = S_DRAIN;
        end else if (mret_req) begin
          is_mret_d = 1'b1;
          info_d    = 5'd0;
          pc_d      = 32'd0;
          state_d   = S_DRAIN;
        end else if (ctrl_mie && (pend_s != 3'b000)) begin
          is_mret_d = 1'b0;
          info_d    = {1'b1, irq_code_s};
          pc_d      = next_pc;
          state_d   = S_DRAIN;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (pipe_idle) begin
          state_d = S_COMMIT;
        end else if ((DRAIN_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d   = S_COMMIT;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_COMMIT: begin
        state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (redirect_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_REDIRECT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    drain_req_d = (state_d != S_IDLE);
    trap_d      = (state_d == S_COMMIT);
    mret_d      = (state_d == S_COMMIT) && is_mret_d;
    if (state_d == S_COMMIT) begin
      trap_pc_d   = pc_d;
      trap_info_d = info_d;
    end else begin
      trap_pc_d   = 32'd0;
      trap_info_d = 5'd0;
    end
  end

  // Redirect target uses the CSR values seen during REDIRECT, i.e. after the commit has landed
  always_comb begin
    if (is_mret_q) begin
      target_s = {mepc[31:2], 2'b00};
    end else begin
`ifdef TRAP_VECTORED_EN
      if (info_q[4] && (mtvec[1:0] == 2'b01)) begin
        target_s = {mtvec[31:2], 2'b00} + {26'd0, info_q[3:0], 2'b00};
      end else begin
        target_s = {mtvec[31:2], 2'b00};
      end
`else
      target_s = {mtvec[31:2], 2'b00};
`endif
    end
  end

  // State, latched fields and output registers
  always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      is_mret_q   <= 1'b0;
      info_q      <= 5'd0;
      pc_q        <= 32'd0;
      timeout_q   <= 1'b0;
      drain_req_q <= 1'b0;
      trap_q      <= 1'b0;
      mret_q      <= 1'b0;
      trap_pc_q   <= 32'd0;
      trap_info_q <= 5'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_mret_q   <= is_mret_d;
      info_q      <= info_d;
      pc_q        <= pc_d;
      timeout_q   <= timeout_d;
      drain_req_q <= drain_req_d;
      trap_q      <= trap_d;
      mret_q      <= mret_d;
      trap_pc_q   <= trap_pc_d;
      trap_info_q <= trap_info_d;
    end
  end

  assign pipe_drain_req = drain_req_q;
  assign ctrl_trap      = trap_q;
  assign ctrl_mret      = mret_q;
  assign trap_pc        = trap_pc_q;
  assign trap_info      = trap_info_q;
  assign drain_timeout  = timeout_q;
  assign redirect_valid = (state_q == S_REDIRECT);
  assign redirect_pc    = (state_q == S_REDIRECT) ? target_s : 32'd0;

endmodule
